// File: rtl/rv_pkg.sv
// Constants shared by the RV32I pipeline stages (fetch, decode, immediate generation).
// No logic here.
// No flow control here.
package rv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 : the architectural bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/if_id_stage_pc_reg.sv
// Program counter with load (redirect), hold (stall) and +4 increment.
// Latency: new value visible one edge after load/increment.
// Backpressure: hold freezes the PC; load overrides hold.
module pc_reg
    import rv_pkg::*;
#(
    parameter int              XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            hold,
    input  logic [XLEN-1:0] load_pc,
    output logic [XLEN-1:0] pc
);

    localparam logic [XLEN-1:0] PC_STEP = 4;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (!hold) begin
            pc <= pc + PC_STEP;   // wraps modulo 2^XLEN
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage plus IF/ID register: drives imem_addr from the PC and latches instr/PC for ID.
// Latency: imem_addr combinational from pc; 1 cycle from pc to id_instr.
// Backpressure: stall holds PC and IF/ID; redirect wins over stall and flushes IF/ID.
module if_id_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = rv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic            id_valid,
    output logic            misalign
);

    localparam logic [XLEN-1:0] PC_STEP = 4;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target_pc;

    // Targets are forced word aligned; the low bits only feed the sticky flag.
    assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (redirect),
        .hold    (stall),
        .load_pc (target_pc),
        .pc      (pc)
    );

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_instr    <= NOP_INSTR;
            id_pc       <= RESET_PC;
            id_pc_plus4 <= RESET_PC + PC_STEP;
            id_valid    <= 1'b0;
            misalign    <= 1'b0;
        end else if (redirect) begin
            // Flush: id_pc/id_pc_plus4 keep their last values for the bubble.
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign <= 1'b1;
            end
        end else if (!stall) begin
            id_instr    <= imem_rdata;
            id_pc       <= pc;
            id_pc_plus4 <= pc + PC_STEP;
            id_valid    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized plus directed bench for if_id_stage against a behavioural model.
// Two instances: default RESET_PC and RESET_PC = 0xFFFF_FFFC for wrap coverage.
module tb_if_id_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic [31:0] addr0, rdata0, instr0, idpc0, idpc40;
    logic        valid0, mis0;
    logic [31:0] addr1, rdata1, instr1, idpc1, idpc41;
    logic        valid1, mis1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] idpc;
        logic [31:0] idpc4;
        logic        valid;
        logic        mis;
    } st_t;

    st_t m0, m1;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem0(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    function automatic logic [31:0] mem1(input logic [31:0] a);
        return (a * 3) ^ 32'h5A5A_0000;
    endfunction

    assign rdata0 = mem0(addr0);
    assign rdata1 = mem1(addr1);

    if_id_stage #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(addr0), .imem_rdata(rdata0),
        .id_instr(instr0), .id_pc(idpc0), .id_pc_plus4(idpc40),
        .id_valid(valid0), .misalign(mis0)
    );

    if_id_stage #(.RESET_PC(RPC1)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(addr1), .imem_rdata(rdata1),
        .id_instr(instr1), .id_pc(idpc1), .id_pc_plus4(idpc41),
        .id_valid(valid1), .misalign(mis1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural behaviour of one rising edge, straight from the stage rules.
    function automatic st_t step(input st_t s, input logic rs, input logic st, input logic rd,
                                 input logic [31:0] rpc, input logic [31:0] rst_pc,
                                 input logic [31:0] word);
        st_t n = s;
        if (!rs) begin
            n.pc = rst_pc; n.instr = NOP; n.idpc = rst_pc; n.idpc4 = rst_pc + 4;
            n.valid = 1'b0; n.mis = 1'b0;
        end else if (rd) begin
            n.pc = rpc - (rpc % 4);
            n.instr = NOP; n.valid = 1'b0;
            if (rpc % 4 != 0) n.mis = 1'b1;
        end else if (!st) begin
            n.instr = word; n.idpc = s.pc; n.idpc4 = s.pc + 4;
            n.pc = s.pc + 4; n.valid = 1'b1;
        end
        return n;
    endfunction

    task automatic cmp_all();
        chk("addr0",  addr0,  m0.pc);
        chk("instr0", instr0, m0.instr);
        chk("idpc0",  idpc0,  m0.idpc);
        chk("idpc40", idpc40, m0.idpc4);
        chk("valid0", {31'b0, valid0}, {31'b0, m0.valid});
        chk("mis0",   {31'b0, mis0},   {31'b0, m0.mis});
        chk("addr1",  addr1,  m1.pc);
        chk("instr1", instr1, m1.instr);
        chk("idpc1",  idpc1,  m1.idpc);
        chk("idpc41", idpc41, m1.idpc4);
        chk("valid1", {31'b0, valid1}, {31'b0, m1.valid});
        chk("mis1",   {31'b0, mis1},   {31'b0, m1.mis});
    endtask

    // Apply the current inputs for one edge, advance the model, compare after the edge.
    task automatic cyc(input logic rs, input logic st, input logic rd, input logic [31:0] rpc);
        rst_n = rs; stall = st; redirect = rd; redirect_pc = rpc;
        m0 = step(m0, rs, st, rd, rpc, 32'h0, mem0(m0.pc));
        m1 = step(m1, rs, st, rd, rpc, RPC1,  mem1(m1.pc));
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    initial begin
        logic [31:0] rpc;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        m0 = '{default: '0};
        m1 = '{default: '0};
        @(negedge clk);

        // Reset, with stall and redirect asserted to show reset wins.
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0102);
        chk("rst_addr",  addr0, 32'h0);
        chk("rst_instr", instr0, NOP);
        chk("rst_pc4",   idpc40, 32'h4);
        chk("rst_wrap4", idpc41, 32'h0);

        // Free run: addr 4 then 8, ID lags by one.
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("run1_addr",  addr0, 32'h4);
        chk("run1_instr", instr0, 32'h1000_0000);
        chk("run1_valid", {31'b0, valid0}, 32'h1);
        chk("wrap_addr",  addr1, 32'h0);
        chk("wrap_pc4",   idpc41, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("run2_addr", addr0, 32'h8);

        // Stall three cycles at pc = 8.
        repeat (3) begin
            cyc(1'b1, 1'b1, 1'b0, '0);
            chk("stall_addr", addr0, 32'h8);
            chk("stall_idpc", idpc0, 32'h4);
        end
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("resume_idpc", idpc0, 32'h8);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("pre_redir_addr", addr0, 32'h10);

        // Redirect to 0x100: one bubble, then the target.
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0100);
        chk("redir_addr",  addr0, 32'h100);
        chk("redir_instr", instr0, NOP);
        chk("redir_valid", {31'b0, valid0}, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("target_idpc",  idpc0, 32'h100);
        chk("target_valid", {31'b0, valid0}, 32'h1);

        // Stall and redirect together: redirect wins.
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        chk("sr_addr",  addr0, 32'h40);
        chk("sr_valid", {31'b0, valid0}, 32'h0);

        // Misaligned target, then an aligned one: flag is sticky.
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0102);
        chk("mis_addr", addr0, 32'h100);
        chk("mis_set",  {31'b0, mis0}, 32'h1);
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0200);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("mis_sticky", {31'b0, mis0}, 32'h1);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("mis_clr",  {31'b0, mis0}, 32'h0);
        chk("clr_addr", addr0, 32'h0);

        // Random traffic, including back-to-back redirects and occasional reset.
        for (int i = 0; i < 400; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0), rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
